mem_stage: RTL and testbench

- MEM pipeline stage, fed directly by the EXE/MEM pipeline register; results go to the MEM/WB register.
- Performs loads and stores over a req/ack data bus, with byte and halfword lane steering and sign/zero extension.
- Asserts stall upstream while a bus transaction is outstanding.
- Non-memory instructions pass through with one-cycle registered latency.

---
 rtl/mem_stage.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM pipeline stage.
// Loads/stores over a single-outstanding req/ack data bus with byte/halfword
// lane steering, sign/zero extension, misalignment and bus-timeout faults.
// Non-memory instructions pass straight through to MEM/WB in one cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access in flight; accept a new instruction every cycle
// BUSY  | dbus_req high, waiting for dbus_ack or the timeout terminal count

`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif
`ifndef PC_INIT
`define PC_INIT 32'hBFC0_0000
`endif

module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_mux_3,
    input  logic        mem_drce,
    input  logic        mem_dwce,
    input  logic        mem_wce,
    input  logic [5:0]  mem_op,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_alu_out,
    input  logic [31:0] mem_rt,
    input  logic [4:0]  mem_rwa,
    output logic        stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        wb_wce,
    output logic [4:0]  wb_rwa,
    output logic [31:0] wb_result,
    output logic [31:0] wb_pc,
    output logic        wb_err
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    // Terminal count of the timeout counter (counts BUSY cycles from 0).
    localparam logic [7:0] TO_TC = 8'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  to_cnt;

    // Instruction context captured on entry to BUSY.
    logic [31:0] lat_addr;
    logic [5:0]  lat_op;
    logic [4:0]  lat_rwa;
    logic        lat_wce;
    logic [31:0] lat_pc;
    logic        lat_mux_3;
    logic        lat_we;

    logic        acc;
    logic        is_byte;
    logic        is_half;
    logic        aligned;
    logic        timeout_hit;
    logic        start_acc;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] load_data;

    assign acc         = mem_drce | mem_dwce;
    assign timeout_hit = (state == BUSY) && (to_cnt == TO_TC);
    assign start_acc   = (state == IDLE) && acc && aligned;

    assign dbus_req  = (state == BUSY);
    assign dbus_addr = {lat_addr[31:2], 2'b00};

    assign stall = start_acc | ((state == BUSY) & ~dbus_ack & ~timeout_hit);

    // Access size decode and alignment check for the incoming instruction.
    always_comb begin
        is_byte = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
        is_half = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
        if (is_byte) begin
            aligned = 1'b1;
        end else if (is_half) begin
            aligned = ~mem_alu_out[0];
        end else begin
            aligned = (mem_alu_out[1:0] == 2'b00);
        end
    end

    // Store lane steering; loads (and unknown ops) use all four lanes.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = mem_rt;
        if (mem_dwce) begin
            case (mem_op)
                OP_SB: begin
                    be_nxt    = 4'b0001 << mem_alu_out[1:0];
                    wdata_nxt = {4{mem_rt[7:0]}};
                end
                OP_SH: begin
                    be_nxt    = mem_alu_out[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{mem_rt[15:0]}};
                end
                default: begin
                    be_nxt    = 4'b1111;
                    wdata_nxt = mem_rt;
                end
            endcase
        end
    end

    // Load lane selection and extension from the latched op/address.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        case (lat_addr[1:0])
            2'd0:    byte_sel = dbus_rdata[7:0];
            2'd1:    byte_sel = dbus_rdata[15:8];
            2'd2:    byte_sel = dbus_rdata[23:16];
            default: byte_sel = dbus_rdata[31:24];
        endcase
        half_sel = lat_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (lat_op)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0, half_sel};
            default: load_data = dbus_rdata;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc && aligned) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (dbus_ack || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timeout counter: counts BUSY cycles, cleared on completion or abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= 8'd0;
        end else if (state == BUSY && !dbus_ack && !timeout_hit) begin
            to_cnt <= to_cnt + 8'd1;
        end else begin
            to_cnt <= 8'd0;
        end
    end

    // Capture the access context; it stays stable on the bus until done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_addr   <= `ZERO_WORD;
            lat_op     <= 6'd0;
            lat_rwa    <= 5'd0;
            lat_wce    <= 1'b0;
            lat_pc     <= `PC_INIT;
            lat_mux_3  <= 1'b0;
            lat_we     <= 1'b0;
            dbus_be    <= 4'd0;
            dbus_wdata <= `ZERO_WORD;
        end else if (start_acc) begin
            lat_addr   <= mem_alu_out;
            lat_op     <= mem_op;
            lat_rwa    <= mem_rwa;
            lat_wce    <= mem_wce;
            lat_pc     <= mem_pc;
            lat_mux_3  <= mem_mux_3;
            lat_we     <= mem_dwce;
            dbus_be    <= be_nxt;
            dbus_wdata <= wdata_nxt;
        end
    end

    assign dbus_we = lat_we;

    // MEM/WB outputs: pass-through, bubble, load result, or fault pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_wce    <= 1'b0;
            wb_rwa    <= 5'd0;
            wb_result <= `ZERO_WORD;
            wb_pc     <= `PC_INIT;
            wb_err    <= 1'b0;
        end else begin
            wb_err <= 1'b0;
            wb_wce <= 1'b0;
            case (state)
                IDLE: begin
                    if (!acc) begin
                        wb_wce    <= mem_wce;
                        wb_rwa    <= mem_rwa;
                        wb_result <= mem_alu_out;
                        wb_pc     <= mem_pc;
                    end else if (!aligned) begin
                        wb_err <= 1'b1;
                        wb_pc  <= mem_pc;
                    end
                end
                BUSY: begin
                    if (dbus_ack) begin
                        wb_pc  <= lat_pc;
                        wb_rwa <= lat_rwa;
                        if (!lat_we) begin
                            wb_wce    <= lat_wce;
                            wb_result <= lat_mux_3 ? load_data : lat_addr;
                        end
                    end else if (timeout_hit) begin
                        wb_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instructions compared against a size/shift based reference model.

module tb_mem_stage;

    localparam int          TO_TB       = 4;
    localparam logic [31:0] PC_INIT_EXP = 32'hBFC0_0000;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_mux_3, mem_drce, mem_dwce, mem_wce;
    logic [5:0]  mem_op;
    logic [31:0] mem_pc, mem_alu_out, mem_rt;
    logic [4:0]  mem_rwa;
    logic        stall, dbus_req, dbus_we, dbus_ack;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        wb_wce, wb_err;
    logic [4:0]  wb_rwa;
    logic [31:0] wb_result, wb_pc;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_res;
    logic [4:0]  exp_rwa;

    mem_stage #(.TIMEOUT(TO_TB)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_mux_3(mem_mux_3), .mem_drce(mem_drce), .mem_dwce(mem_dwce),
        .mem_wce(mem_wce), .mem_op(mem_op), .mem_pc(mem_pc),
        .mem_alu_out(mem_alu_out), .mem_rt(mem_rt), .mem_rwa(mem_rwa),
        .stall(stall), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .wb_wce(wb_wce), .wb_rwa(wb_rwa), .wb_result(wb_result),
        .wb_pc(wb_pc), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // Access size in bytes implied by the opcode.
    function automatic int size_of(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    // Expected load value: shift the addressed lane down, mask, extend.
    function automatic logic [31:0] load_model(input logic [5:0] op,
                                               input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int          sz;
        logic [31:0] v, mask;
        sz = size_of(op);
        v  = rdata >> (8 * int'(addr[1:0]));
        if (sz == 4) return v;
        mask = (32'h1 << (8 * sz)) - 32'h1;
        v = v & mask;
        if ((op == LB || op == LH) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_nop();
        mem_mux_3 = 0; mem_drce = 0; mem_dwce = 0; mem_wce = 0;
        mem_op = 6'd0; mem_pc = 32'd0; mem_alu_out = 32'd0;
        mem_rt = 32'd0; mem_rwa = 5'd0;
    endtask

    // Drive one instruction (called at posedge+1) and follow it to MEM/WB.
    task automatic run_instr(input logic [5:0] op, input logic drce,
                             input logic dwce, input logic wce,
                             input logic mux3, input logic [31:0] pc,
                             input logic [31:0] addr, input logic [31:0] rt,
                             input logic [4:0] rwa, input int w,
                             input logic [31:0] rdata);
        int          sz;
        logic [3:0]  ebe;
        logic [31:0] ewd, eres;
        bit          done;
        mem_op = op; mem_drce = drce; mem_dwce = dwce; mem_wce = wce;
        mem_mux_3 = mux3; mem_pc = pc; mem_alu_out = addr; mem_rt = rt;
        mem_rwa = rwa;
        #1;
        if (!(drce || dwce)) begin
            vectors++; if (stall !== 1'b0) begin miscompares++;
                $display("FAIL alu_stall got %b want 0", stall); end
            @(posedge clk); #1;
            vectors++; if (wb_wce !== wce) begin miscompares++;
                $display("FAIL alu_wce got %b want %b", wb_wce, wce); end
            vectors++; if (wb_result !== addr || wb_rwa !== rwa) begin miscompares++;
                $display("FAIL alu_result got %h/%0d want %h/%0d", wb_result, wb_rwa, addr, rwa); end
            vectors++; if (wb_pc !== pc || wb_err !== 1'b0) begin miscompares++;
                $display("FAIL alu_pc_err got %h/%b want %h/0", wb_pc, wb_err, pc); end
            exp_res = addr; exp_rwa = rwa;
            return;
        end
        sz = size_of(op);
        if ((int'(addr[1:0]) % sz) != 0) begin
            vectors++; if (stall !== 1'b0) begin miscompares++;
                $display("FAIL mis_stall got %b want 0", stall); end
            @(posedge clk); #1;
            vectors++; if (wb_err !== 1'b1 || wb_wce !== 1'b0) begin miscompares++;
                $display("FAIL mis_err got err=%b wce=%b want err=1 wce=0", wb_err, wb_wce); end
            vectors++; if (wb_pc !== pc || dbus_req !== 1'b0) begin miscompares++;
                $display("FAIL mis_pc got %h req=%b want %h req=0", wb_pc, dbus_req, pc); end
            vectors++; if (wb_result !== exp_res || wb_rwa !== exp_rwa) begin miscompares++;
                $display("FAIL mis_hold got %h/%0d want %h/%0d", wb_result, wb_rwa, exp_res, exp_rwa); end
            return;
        end
        vectors++; if (stall !== 1'b1 || dbus_req !== 1'b0) begin miscompares++;
            $display("FAIL entry_stall got stall=%b req=%b want 1/0", stall, dbus_req); end
        @(posedge clk); #1;
        vectors++; if (wb_wce !== 1'b0 || wb_err !== 1'b0) begin miscompares++;
            $display("FAIL entry_bubble got wce=%b err=%b want 0/0", wb_wce, wb_err); end
        if (dwce) begin
            ebe = (sz == 4) ? 4'hF : 4'((((1 << sz) - 1) << int'(addr[1:0])));
            ewd = (sz == 1) ? rt[7:0] * 32'h0101_0101 :
                  (sz == 2) ? rt[15:0] * 32'h0001_0001 : rt;
        end else begin
            ebe = 4'hF;
            ewd = 32'h0;
        end
        done = 0;
        for (int k = 0; k < TO_TB && !done; k++) begin
            vectors++; if (dbus_req !== 1'b1 || dbus_we !== dwce) begin miscompares++;
                $display("FAIL bus_req got req=%b we=%b want 1/%b", dbus_req, dbus_we, dwce); end
            vectors++; if (dbus_addr !== {addr[31:2], 2'b00} || dbus_be !== ebe) begin miscompares++;
                $display("FAIL bus_addr_be got %h/%b want %h/%b", dbus_addr, dbus_be, {addr[31:2], 2'b00}, ebe); end
            if (dwce) begin
                vectors++; if (dbus_wdata !== ewd) begin miscompares++;
                    $display("FAIL bus_wdata got %h want %h", dbus_wdata, ewd); end
            end
            if (k == w) begin
                dbus_ack = 1; dbus_rdata = rdata;
                #1;
                vectors++; if (stall !== 1'b0) begin miscompares++;
                    $display("FAIL ack_stall got %b want 0", stall); end
                @(posedge clk); #1;
                dbus_ack = 0; dbus_rdata = $urandom;
                vectors++; if (wb_wce !== (drce ? wce : 1'b0) || wb_err !== 1'b0) begin miscompares++;
                    $display("FAIL done_wce got wce=%b err=%b want %b/0", wb_wce, wb_err, drce ? wce : 1'b0); end
                vectors++; if (wb_pc !== pc || wb_rwa !== rwa) begin miscompares++;
                    $display("FAIL done_pc got %h/%0d want %h/%0d", wb_pc, wb_rwa, pc, rwa); end
                if (drce) begin
                    eres = mux3 ? load_model(op, addr, rdata) : addr;
                    vectors++; if (wb_result !== eres) begin miscompares++;
                        $display("FAIL load_result got %h want %h", wb_result, eres); end
                    exp_res = eres;
                end
                exp_rwa = rwa;
                done = 1;
            end else if (k == TO_TB - 1) begin
                #1;
                vectors++; if (stall !== 1'b0) begin miscompares++;
                    $display("FAIL to_stall got %b want 0", stall); end
                @(posedge clk); #1;
                vectors++; if (wb_err !== 1'b1 || wb_wce !== 1'b0 || dbus_req !== 1'b0) begin miscompares++;
                    $display("FAIL timeout got err=%b wce=%b req=%b want 1/0/0", wb_err, wb_wce, dbus_req); end
                done = 1;
            end else begin
                #1;
                vectors++; if (stall !== 1'b1) begin miscompares++;
                    $display("FAIL wait_stall got %b want 1", stall); end
                @(posedge clk); #1;
                vectors++; if (wb_wce !== 1'b0 || wb_err !== 1'b0) begin miscompares++;
                    $display("FAIL wait_bubble got wce=%b err=%b want 0/0", wb_wce, wb_err); end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; dbus_ack = 0; dbus_rdata = 0; set_nop();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (dbus_req !== 0 || dbus_we !== 0 || dbus_be !== 0 || stall !== 0) begin miscompares++;
            $display("FAIL reset_bus got req=%b we=%b be=%b stall=%b want 0", dbus_req, dbus_we, dbus_be, stall); end
        vectors++; if (dbus_addr !== 0 || dbus_wdata !== 0) begin miscompares++;
            $display("FAIL reset_bus_data got %h/%h want 0/0", dbus_addr, dbus_wdata); end
        vectors++; if (wb_wce !== 0 || wb_rwa !== 0 || wb_result !== 0 || wb_err !== 0) begin miscompares++;
            $display("FAIL reset_wb got wce=%b rwa=%0d res=%h err=%b want 0", wb_wce, wb_rwa, wb_result, wb_err); end
        vectors++; if (wb_pc !== PC_INIT_EXP) begin miscompares++;
            $display("FAIL reset_pc got %h want %h", wb_pc, PC_INIT_EXP); end
        rst_n = 1;
        exp_res = 0; exp_rwa = 0;
    endtask

    task automatic test_alu();
        run_instr(6'b000000, 0, 0, 1, 0, 32'h0000_0400, 32'h1234, 32'h0, 5'd5, 0, 0);
    endtask

    task automatic test_lb();
        run_instr(LB, 1, 0, 1, 1, 32'h0000_0404, 32'h103, 32'h0, 5'd7, 0, 32'h80FF_0000);
    endtask

    task automatic test_sh();
        run_instr(SH, 0, 1, 1, 0, 32'h0000_0408, 32'h202, 32'hABCD, 5'd9, 3, 32'h0);
    endtask

    task automatic test_misaligned();
        run_instr(LW, 1, 0, 1, 1, 32'h0000_040C, 32'h101, 32'h0, 5'd3, 0, 32'h0);
        run_instr(SH, 0, 1, 0, 0, 32'h0000_0410, 32'h203, 32'h55, 5'd4, 0, 32'h0);
    endtask

    task automatic test_timeout();
        run_instr(LHU, 1, 0, 1, 1, 32'h0000_0414, 32'h0, 32'h0, 5'd6, 100, 32'h0);
    endtask

    task automatic test_reset_busy();
        mem_op = LW; mem_drce = 1; mem_dwce = 0; mem_wce = 1; mem_mux_3 = 1;
        mem_pc = 32'h0000_0500; mem_alu_out = 32'h40; mem_rwa = 5'd2;
        @(posedge clk); #1;
        vectors++; if (dbus_req !== 1'b1) begin miscompares++;
            $display("FAIL rb_req got %b want 1", dbus_req); end
        rst_n = 0; set_nop();
        @(posedge clk); #1;
        vectors++; if (dbus_req !== 0 || stall !== 0 || wb_pc !== PC_INIT_EXP) begin miscompares++;
            $display("FAIL rb_abort got req=%b stall=%b pc=%h want 0/0/%h", dbus_req, stall, wb_pc, PC_INIT_EXP); end
        dbus_ack = 1; dbus_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        vectors++; if (dbus_req !== 0 || wb_wce !== 0 || wb_result !== 0 || wb_err !== 0) begin miscompares++;
            $display("FAIL rb_late_ack got req=%b wce=%b res=%h err=%b want 0", dbus_req, wb_wce, wb_result, wb_err); end
        dbus_ack = 0;
        exp_res = 0; exp_rwa = 0;
    endtask

    task automatic test_back_to_back();
        run_instr(6'b001000, 0, 0, 1, 0, 32'h600, 32'hCAFE_0001, 0, 5'd1, 0, 0);
        run_instr(LW, 1, 0, 1, 1, 32'h604, 32'h1000, 0, 5'd2, 0, 32'h1122_3344);
        run_instr(SW, 0, 1, 0, 0, 32'h608, 32'h1004, 32'h5566_7788, 5'd0, 0, 0);
        run_instr(LH, 1, 0, 1, 1, 32'h60C, 32'h1006, 0, 5'd3, 1, 32'h8001_7FFF);
        run_instr(6'b001000, 0, 0, 1, 0, 32'h610, 32'h77, 0, 5'd4, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
        for (int i = 0; i < 150; i++) begin
            logic [5:0]  op;
            logic [31:0] addr;
            logic        ld;
            int          kind;
            kind = $urandom_range(0, 9);
            addr = $urandom;
            if (kind < 2) begin
                run_instr(6'($urandom_range(0, 31)), 0, 0, 1'($urandom), 1'($urandom),
                          $urandom, addr, $urandom, 5'($urandom), 0, 0);
            end else begin
                op = ops[$urandom_range(0, 7)];
                ld = (op[3] == 1'b0);
                if ($urandom_range(0, 2) != 0) begin
                    if (size_of(op) == 2) addr[0] = 1'b0;
                    if (size_of(op) == 4) addr[1:0] = 2'b00;
                end
                run_instr(op, ld, !ld, 1'($urandom), 1'($urandom), $urandom, addr,
                          $urandom, 5'($urandom), $urandom_range(0, 5), $urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_alu();
        test_lb();
        test_sh();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
